// File: rtl/rng_entropy_packer.sv
// Health-tests ADC samples, extracts/whitens LSBs and packs them into 32-bit words held in an FWFT FIFO.
// Sample-to-out_valid latency 3 cycles; no input backpressure, so words arriving at a full FIFO are dropped and counted.
module rng_entropy_packer #(
  parameter int P_LSB_BITS   = 2,
  parameter int P_VN_ENABLE  = 1,
  parameter int P_FIFO_DEPTH = 16,
  parameter int P_REP_LIMIT  = 31
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [13:0]                   ad_d,
  input  logic                          ad_or,
  input  logic                          ad_valid,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(P_FIFO_DEPTH):0] fifo_level,
  output logic                          rep_alarm,
  output logic [15:0]                   or_count,
  output logic [15:0]                   drop_count
);
  localparam int AW  = $clog2(P_FIFO_DEPTH);
  localparam int LVW = AW + 1;
  localparam int LW  = P_LSB_BITS;

  // S1: acceptance, overrange filter, repetition count
  logic          accept, clean, trip;
  logic [13:0]   prev_q, prev_d;
  logic [7:0]    run_q, run_d;
  logic          alarm_q, alarm_d;
  logic [15:0]   or_cnt_q, or_cnt_d;
  logic          s1_vld_q, s1_vld_d, s1_flush_q;
  logic [LW-1:0] s1_lanes_q;

  always_comb begin
    accept   = enable & ad_valid;
    clean    = accept & ~ad_or;
    prev_d   = prev_q;
    run_d    = run_q;
    or_cnt_d = or_cnt_q;
    if (!enable) begin
      run_d = '0;
    end else if (clean) begin
      prev_d = ad_d;
      if (run_q != 8'd0 && ad_d == prev_q)
        run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
      else
        run_d = 8'd1;
    end
    trip     = clean && (run_d == 8'(P_REP_LIMIT));
    alarm_d  = alarm_q | trip;
    // the tripping sample itself is already blocked
    s1_vld_d = clean & ~alarm_d;
    if (accept && ad_or && or_cnt_q != 16'hFFFF)
      or_cnt_d = or_cnt_q + 16'd1;
  end

  // S2: raw lanes or von Neumann pairing, compacted lane-ascending
  logic          vn_pend_q, vn_pend_d;
  logic [LW-1:0] vn_first_q, vn_first_d;
  logic [LW-1:0] s2_bits_q, s2_bits_d;
  logic [2:0]    s2_cnt_q, s2_cnt_d;
  logic          s2_flush_q;

  always_comb begin
    vn_pend_d  = vn_pend_q;
    vn_first_d = vn_first_q;
    s2_bits_d  = '0;
    s2_cnt_d   = '0;
    if (s1_flush_q) begin
      vn_pend_d = 1'b0;
    end else if (s1_vld_q) begin
      if (P_VN_ENABLE == 0) begin
        s2_bits_d = s1_lanes_q;
        s2_cnt_d  = 3'(LW);
      end else if (!vn_pend_q) begin
        vn_pend_d  = 1'b1;
        vn_first_d = s1_lanes_q;
      end else begin
        vn_pend_d = 1'b0;
        for (int l = 0; l < LW; l++) begin
          if (vn_first_q[l] != s1_lanes_q[l]) begin
            s2_bits_d = s2_bits_d | (LW'(vn_first_q[l]) << s2_cnt_d);
            s2_cnt_d  = s2_cnt_d + 3'd1;
          end
        end
      end
    end
  end

  // S3: LSB-first packer; bits beyond bit 31 seed the next word
  logic [31:0] acc_q, acc_d;
  logic [4:0]  fill_q, fill_d;
  logic [63:0] merged;
  logic [5:0]  total;
  logic        push;

  always_comb begin
    merged = {32'd0, acc_q} | (64'(s2_bits_q) << fill_q);
    total  = {1'b0, fill_q} + {3'b000, s2_cnt_q};
    push   = 1'b0;
    acc_d  = merged[31:0];
    fill_d = total[4:0];
    if (s2_flush_q) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (total[5]) begin
      push  = 1'b1;
      acc_d = merged[63:32];
    end
  end

  // FWFT word FIFO
  logic [31:0]    mem_q [P_FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [LVW-1:0] lvl_q, lvl_d;
  logic           full, pop, wr_en;
  logic [15:0]    drop_q, drop_d;

  always_comb begin
    full   = (lvl_q == LVW'(P_FIFO_DEPTH));
    pop    = (lvl_q != '0) & out_ready;
    wr_en  = push & (~full | pop);
    lvl_d  = lvl_q + LVW'(wr_en) - LVW'(pop);
    drop_d = drop_q;
    if (push && !wr_en && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_q] <= merged[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      run_q      <= '0;
      alarm_q    <= 1'b0;
      or_cnt_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_flush_q <= 1'b0;
      s1_lanes_q <= '0;
      vn_pend_q  <= 1'b0;
      vn_first_q <= '0;
      s2_bits_q  <= '0;
      s2_cnt_q   <= '0;
      s2_flush_q <= 1'b0;
      acc_q      <= '0;
      fill_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      lvl_q      <= '0;
      drop_q     <= '0;
    end else begin
      prev_q     <= prev_d;
      run_q      <= run_d;
      alarm_q    <= alarm_d;
      or_cnt_q   <= or_cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_flush_q <= ~enable;
      s1_lanes_q <= ad_d[LW-1:0];
      vn_pend_q  <= vn_pend_d;
      vn_first_q <= vn_first_d;
      s2_bits_q  <= s2_bits_d;
      s2_cnt_q   <= s2_cnt_d;
      s2_flush_q <= s1_flush_q;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      lvl_q      <= lvl_d;
      drop_q     <= drop_d;
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
    end
  end

  assign out_valid  = (lvl_q != '0);
  assign out_data   = out_valid ? mem_q[rd_q] : 32'd0;
  assign fifo_level = lvl_q;
  assign rep_alarm  = alarm_q;
  assign or_count   = or_cnt_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_rng_entropy_packer.sv
// Bench: raw 2-LSB instance (a) and von Neumann 1-LSB instance (b) share one stimulus stream.
module tb_rng_entropy_packer;
  localparam int REP_LIMIT = 31;

  typedef struct {
    logic [13:0] d;
    logic        o;
    logic        v;
    logic        en;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst, enable, ad_or, ad_valid, out_ready;
  logic [13:0] ad_d;
  logic [31:0] a_out_data, b_out_data;
  logic        a_out_valid, b_out_valid, a_rep_alarm, b_rep_alarm;
  logic [4:0]  a_fifo_level, b_fifo_level;
  logic [15:0] a_or_count, b_or_count, a_drop_count, b_drop_count;

  stim_t       stim[$];
  logic [31:0] got_a[$], got_b[$], mdl_words[$], exp_a[$], exp_b[$];
  int          mdl_or;
  bit          mdl_alarm;
  int          n_cmp = 0, n_fail = 0;
  bit          rand_ready = 1'b0;

  rng_entropy_packer #(.P_LSB_BITS(2), .P_VN_ENABLE(0), .P_FIFO_DEPTH(16), .P_REP_LIMIT(REP_LIMIT)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .ad_d(ad_d), .ad_or(ad_or), .ad_valid(ad_valid),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready), .fifo_level(a_fifo_level),
    .rep_alarm(a_rep_alarm), .or_count(a_or_count), .drop_count(a_drop_count));

  rng_entropy_packer #(.P_LSB_BITS(1), .P_VN_ENABLE(1), .P_FIFO_DEPTH(16), .P_REP_LIMIT(REP_LIMIT)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .ad_d(ad_d), .ad_or(ad_or), .ad_valid(ad_valid),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready), .fifo_level(b_fifo_level),
    .rep_alarm(b_rep_alarm), .or_count(b_or_count), .drop_count(b_drop_count));

  always #5 clk = ~clk;

  // words handed over on each accepted pop
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && out_ready) got_a.push_back(a_out_data);
      if (b_out_valid && out_ready) got_b.push_back(b_out_data);
    end
  end

  // Reference: bit-queue model of the whole stream since reset (assumes no FIFO drops)
  function automatic void build_model(input int lsb, input bit vn);
    bit          bits[$];
    logic [13:0] prev;
    logic [3:0]  first;
    logic [31:0] w;
    int          run;
    bit          alarm, pend;
    mdl_words.delete();
    mdl_or = 0; run = 0; alarm = 0; pend = 0; first = '0; prev = '0;
    foreach (stim[k]) begin
      if (!stim[k].en) begin
        bits.delete(); pend = 0; run = 0;
        continue;
      end
      if (!stim[k].v) continue;
      if (stim[k].o) begin
        if (mdl_or < 65535) mdl_or++;
        continue;
      end
      run  = (run > 0 && stim[k].d == prev) ? run + 1 : 1;
      prev = stim[k].d;
      if (run == REP_LIMIT) alarm = 1;
      if (alarm) continue;
      if (!vn) begin
        for (int l = 0; l < lsb; l++) bits.push_back(stim[k].d[l]);
      end else if (!pend) begin
        pend = 1; first = stim[k].d[3:0];
      end else begin
        pend = 0;
        for (int l = 0; l < lsb; l++)
          if (first[l] != stim[k].d[l]) bits.push_back(first[l]);
      end
      while (bits.size() >= 32) begin
        w = '0;
        for (int b = 0; b < 32; b++) w[b] = bits.pop_front();
        mdl_words.push_back(w);
      end
    end
    mdl_alarm = alarm;
  endfunction

  task automatic send(input logic [13:0] d, input logic o, input logic v, input logic en);
    stim_t s;
    s.d = d; s.o = o; s.v = v; s.en = en;
    stim.push_back(s);
    ad_d = d; ad_or = o; ad_valid = v; enable = en;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    ad_valid = 1'b0; ad_or = 1'b0; enable = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; ad_valid = 1'b0; ad_or = 1'b0; ad_d = '0; out_ready = 1'b0;
    rand_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    stim.delete(); got_a.delete(); got_b.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", a_out_data); end
    n_cmp++; if (a_fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", a_fifo_level); end
    n_cmp++; if (a_rep_alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm got %0b want 0", a_rep_alarm); end
    n_cmp++; if (a_or_count !== 16'd0 || a_drop_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters got or=%0d drop=%0d want 0/0", a_or_count, a_drop_count); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_out_valid got %0b want 0", b_out_valid); end
  endtask

  task automatic test_latency();
    do_reset();
    for (int i = 0; i < 16; i++) send({12'(i), 2'b01}, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n1 got %0b want 0", a_out_valid); end
    idle(1);
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n2 got %0b want 0", a_out_valid); end
    idle(1);
    n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_n3 got %0b want 1", a_out_valid); end
    n_cmp++; if (a_out_data !== 32'h5555_5555) begin n_fail++; $display("FAIL lat_word got %h want 55555555", a_out_data); end
    n_cmp++; if (a_fifo_level !== 5'd1) begin n_fail++; $display("FAIL lat_level got %0d want 1", a_fifo_level); end
  endtask

  task automatic test_vn();
    int k;
    bit seq[8];
    seq = '{0, 1, 1, 0, 0, 0, 1, 1};
    do_reset();
    k = 0;
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < 8; j++) begin
        send({13'(k + 1), 1'(seq[j])}, 1'b0, 1'b1, 1'b1);
        k++;
      end
    idle(4);
    n_cmp++; if (b_fifo_level !== 5'd1) begin n_fail++; $display("FAIL vn_level got %0d want 1", b_fifo_level); end
    n_cmp++; if (b_out_data !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL vn_word got %h want aaaaaaaa", b_out_data); end
  endtask

  task automatic test_rep_alarm();
    do_reset();
    for (int i = 0; i < 30; i++) send(14'h1234, 1'b0, 1'b1, 1'b1);
    send(14'h0AB1, 1'b0, 1'b1, 1'b1);
    idle(3);
    n_cmp++; if (a_rep_alarm !== 1'b0) begin n_fail++; $display("FAIL rep_30_alarm got %0b want 0", a_rep_alarm); end
    for (int i = 0; i < 30; i++) send(14'h2A5C, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (a_rep_alarm !== 1'b0) begin n_fail++; $display("FAIL rep_pre_trip got %0b want 0", a_rep_alarm); end
    send(14'h2A5C, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (a_rep_alarm !== 1'b1) begin n_fail++; $display("FAIL rep_trip got %0b want 1", a_rep_alarm); end
    for (int i = 0; i < 64; i++) send({12'(i + 7), 2'b10}, 1'b0, 1'b1, 1'b1);
    idle(5);
    build_model(2, 1'b0);
    n_cmp++; if (a_fifo_level !== 5'(mdl_words.size())) begin
      n_fail++; $display("FAIL rep_blocked_level got %0d want %0d", a_fifo_level, mdl_words.size()); end
    n_cmp++; if (a_rep_alarm !== mdl_alarm) begin n_fail++; $display("FAIL rep_held got %0b want %0b", a_rep_alarm, mdl_alarm); end
    do_reset();
    n_cmp++; if (a_rep_alarm !== 1'b0) begin n_fail++; $display("FAIL rep_cleared got %0b want 0", a_rep_alarm); end
  endtask

  task automatic test_overrange();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++)
      send({12'(k + 1), 2'($urandom)}, (k == 3 || k == 11 || k == 12 || k == 25 || k == 37), 1'b1, 1'b1);
    idle(6);
    build_model(2, 1'b0);
    exp_a = mdl_words;
    n_cmp++; if (a_or_count !== 16'd5) begin n_fail++; $display("FAIL or_count got %0d want 5", a_or_count); end
    n_cmp++; if (got_a.size() != exp_a.size()) begin
      n_fail++; $display("FAIL or_word_count got %0d want %0d", got_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_cmp++; if (got_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL or_word[%0d] got %h want %h", i, got_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 288; k++) send({12'(k + 1), 2'($urandom)}, 1'b0, 1'b1, 1'b1);
    idle(4);
    build_model(2, 1'b0);
    exp_a = mdl_words;
    n_cmp++; if (a_fifo_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level got %0d want 16", a_fifo_level); end
    n_cmp++; if (a_drop_count !== 16'd2) begin n_fail++; $display("FAIL ovf_drop got %0d want 2", a_drop_count); end
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== exp_a[k]) begin
        n_fail++; $display("FAIL ovf_drain[%0d] got v=%0b %h want v=1 %h", k, a_out_valid, a_out_data, exp_a[k]); end
      idle(1);
    end
    n_cmp++; if (a_out_valid !== 1'b0 || a_fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL ovf_empty got v=%0b lvl=%0d want 0/0", a_out_valid, a_fifo_level); end
  endtask

  task automatic test_enable_flush();
    do_reset();
    for (int k = 0; k < 8; k++) send({12'(k + 1), 2'($urandom)}, 1'b0, 1'b1, 1'b1);
    send(14'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) send({12'(k + 100), 2'($urandom)}, 1'b0, 1'b1, 1'b1);
    idle(4);
    build_model(2, 1'b0);
    exp_a = mdl_words;
    n_cmp++; if (a_fifo_level !== 5'd1) begin n_fail++; $display("FAIL flush_level got %0d want 1", a_fifo_level); end
    n_cmp++; if (a_out_data !== exp_a[0]) begin n_fail++; $display("FAIL flush_word got %h want %h", a_out_data, exp_a[0]); end
    for (int k = 0; k < 36; k++) send({12'(k + 300), 2'($urandom)}, (k % 9 == 4), 1'b1, 1'b1);
    idle(4);
    n_cmp++; if (a_fifo_level !== 5'd3 || a_or_count !== 16'd4) begin
      n_fail++; $display("FAIL preload got lvl=%0d or=%0d want 3/4", a_fifo_level, a_or_count); end
    rst = 1'b1;
    idle(1);
    n_cmp++; if (a_out_valid !== 1'b0 || a_fifo_level !== 5'd0 || a_out_data !== 32'd0) begin
      n_fail++; $display("FAIL rst_fifo got v=%0b lvl=%0d d=%h want 0", a_out_valid, a_fifo_level, a_out_data); end
    n_cmp++; if (a_or_count !== 16'd0 || a_drop_count !== 16'd0 || a_rep_alarm !== 1'b0) begin
      n_fail++; $display("FAIL rst_counters got or=%0d drop=%0d al=%0b want 0", a_or_count, a_drop_count, a_rep_alarm); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [13:0] d, prev;
    do_reset();
    rand_ready = 1'b1;
    prev = '0;
    for (int k = 0; k < 800; k++) begin
      d = ($urandom_range(0, 3) == 0) ? prev : 14'($urandom);
      prev = d;
      send(d, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) != 0));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(40);
    build_model(2, 1'b0);
    exp_a = mdl_words;
    n_cmp++; if (a_or_count !== 16'(mdl_or)) begin n_fail++; $display("FAIL rnd_or got %0d want %0d", a_or_count, mdl_or); end
    n_cmp++; if (a_drop_count !== 16'd0) begin n_fail++; $display("FAIL rnd_drop got %0d want 0", a_drop_count); end
    build_model(1, 1'b1);
    exp_b = mdl_words;
    n_cmp++; if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      n_fail++; $display("FAIL rnd_counts got a=%0d b=%0d want a=%0d b=%0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size()); end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_cmp++; if (got_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL rnd_a[%0d] got %h want %h", i, got_a[i], exp_a[i]); end
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      n_cmp++; if (got_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL rnd_b[%0d] got %h want %h", i, got_b[i], exp_b[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vn();
    test_rep_alarm();
    test_overrange();
    test_overflow();
    test_enable_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
